tl_ul_scratchpad_responder: RTL and testbench
=============================================

// Module: tl_ul_scratchpad_responder
// PURPOSE
//   TileLink-UL responder (manager end) driving the D channel in answer to A-channel requests; the protocol
//   counterpart of the TL monitors. Backs a byte-masked scratchpad: Get / PutFullData / PutPartialData,
//   single-beat only, one outstanding response. Sits behind a crossbar port as a test/debug memory target.
// PARAMETERS
//   ADDR_W     30           A-channel address width
//   SRC_W      7            source ID width (A and D)
//   SIZE_W     4            size field width (log2 bytes)
//   DATA_W     64           beat width in bits; MAX_LGSZ = log2(DATA_W/8) = 3
//   DEPTH      512          scratchpad depth in DATA_W words
//   BASE_ADDR  30'h0800_0000 base of decoded range; range = DEPTH*DATA_W/8 bytes, aligned to its size
// PORTS
//   clock      in   1       sole clock; all state on rising edge
//   reset_n    in   1       asynchronous, active-low reset
//   a_valid    in   1       A request valid
//   a_ready    out  1       A request accepted when a_valid & a_ready
//   a_opcode   in   3       0 PutFullData, 1 PutPartialData, 4 Get; all others unsupported
//   a_param    in   3       must be 0; nonzero is a protocol error
//   a_size     in   SIZE_W  log2 transfer bytes
//   a_source   in   SRC_W   requester ID, echoed on D
//   a_address  in   ADDR_W  byte address
//   a_mask     in   DATA_W/8 byte lanes
//   a_data     in   DATA_W  write data
//   d_valid    out  1       D response valid
//   d_ready    in   1       D response accepted when d_valid & d_ready
//   d_opcode   out  3       0 AccessAck (Put), 1 AccessAckData (Get and unsupported-read)
//   d_size     out  SIZE_W  echo of a_size
//   d_source   out  SRC_W   echo of a_source
//   d_denied   out  1       request rejected; memory untouched
//   d_corrupt  out  1       = d_denied when d_opcode==1, else 0
//   d_data     out  DATA_W  read data; 0 when denied or AccessAck
//   proto_err  out  1       one-cycle pulse on A fire carrying a protocol violation
// BEHAVIOUR
//   - Reset (async assert, sync deassert by upstream): d_valid=0, d_opcode/size/source/data=0,
//     d_denied=d_corrupt=0, proto_err=0, a_ready=1. Scratchpad contents NOT reset (undefined).
//   - Single response register, states IDLE / RESP. a_ready = !d_valid | d_ready (pass-through drain);
//     A fire in IDLE or with same-cycle D fire -> RESP next cycle. D fire without A fire -> IDLE.
//   - Latency: A fire at cycle N -> d_valid=1 at N+1. Full-throughput back-to-back with d_ready held 1.
//   - d_* stable while d_valid & !d_ready (no combinational path from a_* to d_*).
//   - Denied when any of: address outside [BASE_ADDR, BASE_ADDR+range); a_size > MAX_LGSZ;
//     opcode not in {0,1,4}. Denied Get/unsupported -> d_opcode=1, d_corrupt=1; denied Put -> d_opcode=0.
//   - proto_err (also denies) when: a_param!=0; address not aligned to 2^a_size; PutFull with a_mask not
//     exactly the lanes covered by size/address; Get with a_mask not exactly those lanes; PutPartial with
//     mask bits outside those lanes. PutPartial with mask==0 is legal: AccessAck, no write.
//   - Write: on A fire of accepted Put, lanes with a_mask=1 written at word index
//     (a_address-BASE_ADDR)>>MAX_LGSZ; other lanes preserved.
//   - Read: on A fire of accepted Get, full word captured to d_data (all lanes, unmasked);
//     Get same cycle as a prior Put to same word returns the prior Put's data (write completes at N).
//   - d_ready asserted while d_valid=0 has no effect. a_valid may drop without fire; nothing latched.
//   - reset_n asserted mid-response: response dropped, d_valid=0 immediately.
// STRUCTURE
//   - Package tl_ul_pkg: opcode enums (A: PUT_FULL=0, PUT_PARTIAL=1, ARITH=2, LOGIC=3, GET=4, INTENT=5;
//     D: ACCESS_ACK=0, ACCESS_ACK_DATA=1), lane-mask function mask_for(size,addr_lo), MAX_LGSZ helper.
//   - Sub-module tl_scratch_mem: DEPTH x DATA_W array, byte-write-enable, 1-cycle registered read.
//   - Top: request decode/check (comb), response register + 2-state FSM.
// TESTING
//   - PutFull size3 addr BASE+0x10 data 64'h1122334455667788 mask 8'hFF, then Get size3 same addr
//     -> AccessAck then AccessAckData data 64'h1122334455667788, denied=0, source echoed.
//   - PutPartial size3 addr BASE+0x10 mask 8'h0F data 64'hAAAAAAAA_BBBBBBBB -> later Get returns
//     64'h11223344_BBBBBBBB.
//   - Get addr BASE+range (first out-of-range byte) source 7'h5A -> d_opcode=1, denied=1, corrupt=1,
//     data 0, source 7'h5A, proto_err=0.
//   - Get size2 addr BASE+0x2 -> misaligned: proto_err pulse, denied=1; opcode 2 (Arith) -> denied, AccessAckData.
//   - d_ready held 0 for 5 cycles after first Get: a_ready=0, d_* stable; release -> 10 back-to-back
//     Gets complete one per cycle, sources in order.
//   - reset_n pulsed low while d_valid=1 -> d_valid=0 same cycle, a_ready=1 after release.

Source files
------------

// File: rtl/tl_ul_pkg.sv
// Shared TileLink-UL definitions: channel opcodes and lane-mask helpers used
// by the scratchpad responder and its storage.
package tl_ul_pkg;

    typedef enum logic [2:0] {
        PUT_FULL    = 3'd0,
        PUT_PARTIAL = 3'd1,
        ARITH       = 3'd2,
        LOGIC       = 3'd3,
        GET         = 3'd4,
        INTENT      = 3'd5
    } a_opcode_e;

    typedef enum logic [2:0] {
        ACCESS_ACK      = 3'd0,
        ACCESS_ACK_DATA = 3'd1
    } d_opcode_e;

    localparam int MAX_LANES = 128;

    function automatic int max_lgsz(input int data_w);
        return $clog2(data_w / 8);
    endfunction

    // Byte lanes touched by a naturally aligned transfer of 2^size bytes;
    // sizes at or beyond the beat width cover every lane.
    function automatic logic [MAX_LANES-1:0] mask_for(input int size, input logic [6:0] addr_lo,
                                                      input int lanes);
        logic [MAX_LANES-1:0] m;
        int bytes;
        int lo;
        m = '0;
        if (size > 6 || (1 << size) >= lanes)
            bytes = lanes;
        else
            bytes = 1 << size;
        lo = int'(addr_lo) & (lanes - 1) & ~(bytes - 1);
        for (int i = 0; i < MAX_LANES; i++)
            m[i] = (i >= lo) && (i < lo + bytes);
        return m;
    endfunction

endpackage

// File: rtl/tl_scratch_mem.sv
// Byte-write-enabled scratchpad array with a registered read port; contents
// are deliberately not reset.
module tl_scratch_mem
    import tl_ul_pkg::*;
#(
    parameter int DATA_W = 64,
    parameter int DEPTH  = 512,
    localparam int STRB_W = DATA_W / 8,
    localparam int IDX_W  = $clog2(DEPTH)
) (
    input  logic              clock,
    input  logic              we,
    input  logic              re,
    input  logic [IDX_W-1:0]  idx,
    input  logic [STRB_W-1:0] be,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] mem [DEPTH];

    always_ff @(posedge clock) begin
        if (we) begin
            for (int i = 0; i < STRB_W; i++) begin
                if (be[i])
                    mem[idx][8*i +: 8] <= wdata[8*i +: 8];
            end
        end
        // rdata only moves on a new accepted Get, so it holds through a stalled response
        if (re)
            rdata <= mem[idx];
    end

endmodule

// File: rtl/tl_ul_scratchpad_responder.sv
// TileLink-UL manager answering single-beat Get/Put requests from a byte-masked
// scratchpad, with one registered response in flight.
//
//   state | meaning
//   IDLE  | no response held, D channel idle
//   RESP  | response registered and presented on D until accepted
module tl_ul_scratchpad_responder
    import tl_ul_pkg::*;
#(
    parameter int ADDR_W = 30,
    parameter int SRC_W  = 7,
    parameter int SIZE_W = 4,
    parameter int DATA_W = 64,
    parameter int DEPTH  = 512,
    parameter logic [ADDR_W-1:0] BASE_ADDR = 30'h0800_0000
) (
    input  logic                clock,
    input  logic                reset_n,
    input  logic                a_valid,
    output logic                a_ready,
    input  logic [2:0]          a_opcode,
    input  logic [2:0]          a_param,
    input  logic [SIZE_W-1:0]   a_size,
    input  logic [SRC_W-1:0]    a_source,
    input  logic [ADDR_W-1:0]   a_address,
    input  logic [DATA_W/8-1:0] a_mask,
    input  logic [DATA_W-1:0]   a_data,
    output logic                d_valid,
    input  logic                d_ready,
    output logic [2:0]          d_opcode,
    output logic [SIZE_W-1:0]   d_size,
    output logic [SRC_W-1:0]    d_source,
    output logic                d_denied,
    output logic                d_corrupt,
    output logic [DATA_W-1:0]   d_data,
    output logic                proto_err
);

    localparam int STRB_W = DATA_W / 8;
    localparam int LGSZ   = max_lgsz(DATA_W);
    localparam int RANGE  = DEPTH * STRB_W;
    localparam int IDX_W  = $clog2(DEPTH);

    typedef enum logic {IDLE, RESP} state_e;

    state_e            state;
    logic              data_sel;
    logic [DATA_W-1:0] rdata;

    logic [ADDR_W-1:0] offset;
    logic [ADDR_W-1:0] align_mask;
    logic [STRB_W-1:0] lane_mask;
    logic              in_range, size_ok, op_ok, is_put, is_get;
    logic              misaligned, mask_err, proto_viol, denied;
    logic              a_fire, d_fire;

    assign offset     = a_address - BASE_ADDR;
    assign in_range   = (a_address >= BASE_ADDR) && (offset < ADDR_W'(RANGE));
    assign size_ok    = a_size <= SIZE_W'(LGSZ);
    assign is_put     = (a_opcode == PUT_FULL) || (a_opcode == PUT_PARTIAL);
    assign is_get     = a_opcode == GET;
    assign op_ok      = is_put || is_get;

    assign align_mask = (ADDR_W'(1) << a_size) - ADDR_W'(1);
    assign misaligned = |(a_address & align_mask);
    assign lane_mask  = STRB_W'(mask_for(int'(a_size), 7'(a_address[LGSZ-1:0]), STRB_W));

    // Lane checks only mean something once the size fits in a beat; oversize is denied anyway.
    always_comb begin
        mask_err = 1'b0;
        if (size_ok) begin
            if (a_opcode == PUT_FULL || a_opcode == GET)
                mask_err = a_mask != lane_mask;
            else if (a_opcode == PUT_PARTIAL)
                mask_err = |(a_mask & ~lane_mask);
        end
    end

    assign proto_viol = (a_param != 3'd0) || misaligned || mask_err;
    assign denied     = !in_range || !size_ok || !op_ok || proto_viol;

    assign d_valid    = state == RESP;
    assign a_ready    = !d_valid || d_ready;
    assign a_fire     = a_valid && a_ready;
    assign d_fire     = d_valid && d_ready;
    assign proto_err  = a_fire && proto_viol;
    assign d_data     = data_sel ? rdata : '0;

    tl_scratch_mem #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH)
    ) u_mem (
        .clock (clock),
        .we    (a_fire && !denied && is_put),
        .re    (a_fire && !denied && is_get),
        .idx   (offset[LGSZ +: IDX_W]),
        .be    (a_mask),
        .wdata (a_data),
        .rdata (rdata)
    );

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state     <= IDLE;
            d_opcode  <= '0;
            d_size    <= '0;
            d_source  <= '0;
            d_denied  <= 1'b0;
            d_corrupt <= 1'b0;
            data_sel  <= 1'b0;
        end else begin
            case (state)
                IDLE, RESP: begin
                    // In RESP an A fire implies d_ready, so the old response drains as the new one loads.
                    if (a_fire) begin
                        state     <= RESP;
                        d_opcode  <= is_put ? ACCESS_ACK : ACCESS_ACK_DATA;
                        d_size    <= a_size;
                        d_source  <= a_source;
                        d_denied  <= denied;
                        d_corrupt <= denied && !is_put;
                        data_sel  <= is_get && !denied;
                    end else if (d_fire) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_tl_ul_scratchpad_responder.sv
// Bench for the TL-UL scratchpad responder: directed protocol cases plus
// randomized traffic scored against a behavioural memory/response model.
module tb_tl_ul_scratchpad_responder;

    localparam logic [29:0] BASE  = 30'h0800_0000;
    localparam longint      RANGE = 4096;

    logic        clock = 1'b0;
    logic        reset_n = 1'b0;
    logic        a_valid = 1'b0;
    logic        a_ready;
    logic [2:0]  a_opcode = '0;
    logic [2:0]  a_param = '0;
    logic [3:0]  a_size = '0;
    logic [6:0]  a_source = '0;
    logic [29:0] a_address = '0;
    logic [7:0]  a_mask = '0;
    logic [63:0] a_data = '0;
    logic        d_valid;
    logic        d_ready;
    logic [2:0]  d_opcode;
    logic [3:0]  d_size;
    logic [6:0]  d_source;
    logic        d_denied;
    logic        d_corrupt;
    logic [63:0] d_data;
    logic        proto_err;

    logic rdy_rand = 1'b0;
    logic rdy_fix = 1'b1;
    logic rnd_ready = 1'b1;
    assign d_ready = rdy_rand ? rnd_ready : rdy_fix;

    int total = 0;
    int bad = 0;

    tl_ul_scratchpad_responder dut (
        .clock     (clock),
        .reset_n   (reset_n),
        .a_valid   (a_valid),
        .a_ready   (a_ready),
        .a_opcode  (a_opcode),
        .a_param   (a_param),
        .a_size    (a_size),
        .a_source  (a_source),
        .a_address (a_address),
        .a_mask    (a_mask),
        .a_data    (a_data),
        .d_valid   (d_valid),
        .d_ready   (d_ready),
        .d_opcode  (d_opcode),
        .d_size    (d_size),
        .d_source  (d_source),
        .d_denied  (d_denied),
        .d_corrupt (d_corrupt),
        .d_data    (d_data),
        .proto_err (proto_err)
    );

    always #5 clock = ~clock;

    always @(posedge clock) begin
        #1;
        rnd_ready = ($urandom_range(0, 3) != 0);
    end

    typedef struct {
        logic [2:0]  op;
        logic [2:0]  param;
        logic [3:0]  size;
        logic [6:0]  src;
        logic [29:0] addr;
        logic [7:0]  mask;
        logic [63:0] data;
    } req_t;

    typedef struct {
        logic [2:0]  op;
        logic        denied;
        logic        corrupt;
        logic [3:0]  size;
        logic [6:0]  src;
        logic [63:0] data;
        logic        perr;
    } rsp_t;

    logic [63:0] mdl [0:511];
    rsp_t        exp_q [$];

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [7:0] lanes_of(input logic [3:0] size, input logic [29:0] addr);
        int b = 1 << size;
        int lo = int'(addr % 8);
        logic [7:0] m = '0;
        for (int i = 0; i < 8; i++)
            if (i >= lo && i < lo + b) m[i] = 1'b1;
        return m;
    endfunction

    function automatic rsp_t predict(input req_t r);
        rsp_t   p;
        longint a = longint'(r.addr);
        logic   inr = (a >= longint'(BASE)) && (a < longint'(BASE) + RANGE);
        logic   size_ok = r.size <= 4'd3;
        logic   is_put = (r.op == 3'd0) || (r.op == 3'd1);
        logic   is_get = r.op == 3'd4;
        logic   perr;
        logic   den;
        logic [7:0] ln;
        perr = (r.param != 3'd0) || ((a % (longint'(1) << r.size)) != 0);
        if (size_ok) begin
            ln = lanes_of(r.size, r.addr);
            if (r.op == 3'd0 || r.op == 3'd4) perr = perr || (r.mask != ln);
            if (r.op == 3'd1) perr = perr || ((r.mask & ~ln) != 8'h00);
        end
        den       = !inr || !size_ok || !(is_put || is_get) || perr;
        p.op      = is_put ? 3'd0 : 3'd1;
        p.denied  = den;
        p.corrupt = den && !is_put;
        p.size    = r.size;
        p.src     = r.src;
        p.perr    = perr;
        p.data    = (is_get && !den) ? mdl[int'((a - longint'(BASE)) / 8)] : 64'h0;
        return p;
    endfunction

    // Scoreboard: responses retire in order; the A fire updates the memory model.
    int   rst_cnt = 0;
    int   rst_seen = 0;
    logic prev_fire = 1'b0;
    logic prev_hold = 1'b0;
    logic [2:0]  h_op;
    logic [6:0]  h_src;
    logic [3:0]  h_size;
    logic [63:0] h_data;
    logic        h_den, h_cor;

    always @(negedge reset_n) rst_cnt++;

    always @(negedge clock) begin
        rsp_t e;
        rsp_t p;
        req_t r;
        logic fire;
        if (rst_cnt != rst_seen) begin
            rst_seen = rst_cnt;
            exp_q.delete();
            prev_fire = 1'b0;
            prev_hold = 1'b0;
        end else if (reset_n) begin
            if (prev_fire) check_eq("latency_valid", d_valid, 1'b1);
            if (prev_hold) begin
                check_eq("hold_valid", d_valid, 1'b1);
                check_eq("hold_opcode", d_opcode, h_op);
                check_eq("hold_source", d_source, h_src);
                check_eq("hold_size", d_size, h_size);
                check_eq("hold_data", d_data, h_data);
                check_eq("hold_denied", d_denied, h_den);
                check_eq("hold_corrupt", d_corrupt, h_cor);
            end
            if (d_valid && d_ready) begin
                check_eq("resp_pending", exp_q.size() > 0, 1'b1);
                if (exp_q.size() > 0) begin
                    e = exp_q.pop_front();
                    check_eq("sb_opcode", d_opcode, e.op);
                    check_eq("sb_denied", d_denied, e.denied);
                    check_eq("sb_corrupt", d_corrupt, e.corrupt);
                    check_eq("sb_size", d_size, e.size);
                    check_eq("sb_source", d_source, e.src);
                    check_eq("sb_data", d_data, e.data);
                end
            end
            fire = a_valid && a_ready;
            if (fire) begin
                r = '{a_opcode, a_param, a_size, a_source, a_address, a_mask, a_data};
                p = predict(r);
                check_eq("sb_proto_err", proto_err, p.perr);
                exp_q.push_back(p);
                if ((r.op == 3'd0 || r.op == 3'd1) && !p.denied) begin
                    for (int i = 0; i < 8; i++)
                        if (r.mask[i])
                            mdl[int'((longint'(r.addr) - longint'(BASE)) / 8)][8*i +: 8] = r.data[8*i +: 8];
                end
            end else begin
                check_eq("idle_proto_err", proto_err, 1'b0);
            end
            prev_fire = fire;
            prev_hold = d_valid && !d_ready;
            h_op = d_opcode; h_src = d_source; h_size = d_size;
            h_data = d_data; h_den = d_denied; h_cor = d_corrupt;
        end
    end

    function automatic req_t mk(input logic [2:0] op, input logic [2:0] param, input logic [3:0] size,
                                input logic [6:0] src, input logic [29:0] addr, input logic [7:0] mask,
                                input logic [63:0] data);
        req_t r;
        r = '{op, param, size, src, addr, mask, data};
        return r;
    endfunction

    task automatic drive(input req_t r);
        a_valid = 1'b1; a_opcode = r.op; a_param = r.param; a_size = r.size;
        a_source = r.src; a_address = r.addr; a_mask = r.mask; a_data = r.data;
    endtask

    task automatic send(input req_t r, output int waited, output logic perr);
        logic done = 1'b0;
        waited = 0;
        perr = 1'b0;
        drive(r);
        while (!done && waited < 200) begin
            @(negedge clock);
            waited++;
            if (a_ready) begin
                done = 1'b1;
                perr = proto_err;
            end
            @(posedge clock);
            #1;
        end
        if (!done) check_eq("a_fire_timeout", done, 1'b1);
        a_valid = 1'b0;
    endtask

    task automatic expect_resp(input string tag, input logic [2:0] op, input logic den, input logic cor,
                               input logic [6:0] src, input logic [63:0] data);
        @(negedge clock);
        check_eq({tag, "_valid"}, d_valid, 1'b1);
        check_eq({tag, "_opcode"}, d_opcode, op);
        check_eq({tag, "_denied"}, d_denied, den);
        check_eq({tag, "_corrupt"}, d_corrupt, cor);
        check_eq({tag, "_source"}, d_source, src);
        check_eq({tag, "_data"}, d_data, data);
        @(posedge clock);
        #1;
    endtask

    function automatic req_t rand_req();
        req_t r;
        int   k = $urandom_range(0, 19);
        int   sel;
        logic [7:0] ln;
        if (k <= 5)       r.op = 3'd4;
        else if (k <= 10) r.op = 3'd0;
        else if (k <= 15) r.op = 3'd1;
        else begin
            sel = $urandom_range(0, 4);
            r.op = (sel == 0) ? 3'd2 : (sel == 1) ? 3'd3 : (sel == 2) ? 3'd5 : (sel == 3) ? 3'd6 : 3'd7;
        end
        r.param = ($urandom_range(0, 19) == 0) ? 3'($urandom_range(1, 7)) : 3'd0;
        r.size  = ($urandom_range(0, 9) == 0) ? 4'($urandom_range(4, 7)) : 4'($urandom_range(0, 3));
        r.src   = 7'($urandom);
        r.data  = {$urandom, $urandom};
        sel = $urandom_range(0, 99);
        if (sel < 8)
            r.addr = BASE + 30'($urandom_range(0, 511) * 8 + $urandom_range(0, 7));
        else if (sel < 12)
            r.addr = BASE + 30'(RANGE) + 30'($urandom_range(0, 15) * 8);
        else if (sel < 15)
            r.addr = BASE - 30'($urandom_range(1, 16) * 8);
        else
            r.addr = BASE + 30'($urandom_range(0, 511) * 8)
                   + ((r.size <= 4'd3) ? 30'(($urandom_range(0, 7) >> r.size) << r.size) : 30'd0);
        ln = (r.size <= 4'd3) ? lanes_of(r.size, r.addr) : 8'hFF;
        if ($urandom_range(0, 19) == 0)
            r.mask = 8'($urandom);
        else if (r.op == 3'd1)
            r.mask = ln & 8'($urandom);
        else
            r.mask = ln;
        return r;
    endfunction

    initial begin : watchdog
        #900000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "bench timed out");
    end

    initial begin : main
        int   w;
        int   sum;
        logic pe;
        int   guard;

        repeat (2) @(negedge clock);
        check_eq("rst_d_valid", d_valid, 1'b0);
        check_eq("rst_a_ready", a_ready, 1'b1);
        check_eq("rst_d_opcode", d_opcode, 3'd0);
        check_eq("rst_d_size", d_size, 4'd0);
        check_eq("rst_d_source", d_source, 7'd0);
        check_eq("rst_d_data", d_data, 64'd0);
        check_eq("rst_d_denied", d_denied, 1'b0);
        check_eq("rst_d_corrupt", d_corrupt, 1'b0);
        check_eq("rst_proto_err", proto_err, 1'b0);
        @(posedge clock);
        #1;
        reset_n = 1'b1;

        for (int i = 0; i < 512; i++)
            send(mk(3'd0, 3'd0, 4'd3, 7'(i), BASE + 30'(i * 8), 8'hFF, {$urandom, $urandom}), w, pe);

        send(mk(3'd0, 3'd0, 4'd3, 7'h11, BASE + 30'h10, 8'hFF, 64'h1122334455667788), w, pe);
        expect_resp("putfull", 3'd0, 1'b0, 1'b0, 7'h11, 64'h0);
        send(mk(3'd4, 3'd0, 4'd3, 7'h22, BASE + 30'h10, 8'hFF, 64'h0), w, pe);
        expect_resp("get_full", 3'd1, 1'b0, 1'b0, 7'h22, 64'h1122334455667788);

        send(mk(3'd1, 3'd0, 4'd3, 7'h23, BASE + 30'h10, 8'h0F, 64'hAAAAAAAA_BBBBBBBB), w, pe);
        expect_resp("putpart", 3'd0, 1'b0, 1'b0, 7'h23, 64'h0);
        send(mk(3'd4, 3'd0, 4'd3, 7'h24, BASE + 30'h10, 8'hFF, 64'h0), w, pe);
        expect_resp("get_part", 3'd1, 1'b0, 1'b0, 7'h24, 64'h11223344_BBBBBBBB);

        send(mk(3'd1, 3'd0, 4'd3, 7'h25, BASE + 30'h18, 8'h00, 64'hDEADBEEF_DEADBEEF), w, pe);
        check_eq("mask0_proto_err", pe, 1'b0);
        expect_resp("mask0", 3'd0, 1'b0, 1'b0, 7'h25, 64'h0);

        send(mk(3'd0, 3'd0, 4'd3, 7'h26, BASE + 30'(RANGE - 8), 8'hFF, 64'h0F0E0D0C_0B0A0908), w, pe);
        expect_resp("put_last", 3'd0, 1'b0, 1'b0, 7'h26, 64'h0);
        send(mk(3'd4, 3'd0, 4'd3, 7'h27, BASE + 30'(RANGE - 8), 8'hFF, 64'h0), w, pe);
        expect_resp("get_last", 3'd1, 1'b0, 1'b0, 7'h27, 64'h0F0E0D0C_0B0A0908);

        send(mk(3'd4, 3'd0, 4'd3, 7'h5A, BASE + 30'(RANGE), 8'hFF, 64'h0), w, pe);
        check_eq("oor_proto_err", pe, 1'b0);
        expect_resp("oor_get", 3'd1, 1'b1, 1'b1, 7'h5A, 64'h0);

        send(mk(3'd0, 3'd0, 4'd3, 7'h5B, BASE - 30'd8, 8'hFF, 64'h1234), w, pe);
        expect_resp("oor_put", 3'd0, 1'b1, 1'b0, 7'h5B, 64'h0);

        send(mk(3'd4, 3'd0, 4'd2, 7'h31, BASE + 30'h2, 8'h0F, 64'h0), w, pe);
        check_eq("misalign_proto_err", pe, 1'b1);
        expect_resp("misalign", 3'd1, 1'b1, 1'b1, 7'h31, 64'h0);

        send(mk(3'd2, 3'd0, 4'd3, 7'h32, BASE + 30'h18, 8'hFF, 64'h0), w, pe);
        check_eq("arith_proto_err", pe, 1'b0);
        expect_resp("arith", 3'd1, 1'b1, 1'b1, 7'h32, 64'h0);

        send(mk(3'd4, 3'd1, 4'd3, 7'h33, BASE + 30'h10, 8'hFF, 64'h0), w, pe);
        check_eq("param_proto_err", pe, 1'b1);
        expect_resp("param", 3'd1, 1'b1, 1'b1, 7'h33, 64'h0);

        send(mk(3'd0, 3'd0, 4'd3, 7'h34, BASE + 30'h10, 8'h7F, 64'h0), w, pe);
        check_eq("pfmask_proto_err", pe, 1'b1);
        expect_resp("pfmask", 3'd0, 1'b1, 1'b0, 7'h34, 64'h0);

        rdy_fix = 1'b0;
        send(mk(3'd4, 3'd0, 4'd3, 7'h30, BASE + 30'h10, 8'hFF, 64'h0), w, pe);
        drive(mk(3'd4, 3'd0, 4'd3, 7'h40, BASE, 8'hFF, 64'h0));
        for (int i = 0; i < 5; i++) begin
            @(negedge clock);
            check_eq("stall_a_ready", a_ready, 1'b0);
            check_eq("stall_d_valid", d_valid, 1'b1);
            check_eq("stall_source", d_source, 7'h30);
            check_eq("stall_data", d_data, 64'h11223344_BBBBBBBB);
        end
        @(posedge clock);
        #1;
        rdy_fix = 1'b1;
        sum = 0;
        for (int i = 0; i < 10; i++) begin
            send(mk(3'd4, 3'd0, 4'd3, 7'(7'h40 + i), BASE + 30'(i * 8), 8'hFF, 64'h0), w, pe);
            sum += w;
        end
        check_eq("b2b_cycles", sum, 10);
        repeat (2) @(posedge clock);
        #1;

        rdy_fix = 1'b0;
        send(mk(3'd4, 3'd0, 4'd3, 7'h50, BASE + 30'h10, 8'hFF, 64'h0), w, pe);
        @(negedge clock);
        check_eq("prerst_d_valid", d_valid, 1'b1);
        #1 reset_n = 1'b0;
        #1;
        check_eq("midrst_d_valid", d_valid, 1'b0);
        check_eq("midrst_a_ready", a_ready, 1'b1);
        @(posedge clock);
        #1 reset_n = 1'b1;
        @(negedge clock);
        check_eq("postrst_a_ready", a_ready, 1'b1);
        check_eq("postrst_d_valid", d_valid, 1'b0);
        @(posedge clock);
        #1;
        rdy_fix = 1'b1;

        rdy_rand = 1'b1;
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 3) == 0) begin
                @(posedge clock);
                #1;
            end
            send(rand_req(), w, pe);
        end
        rdy_rand = 1'b0;
        guard = 0;
        while ((exp_q.size() != 0 || d_valid) && guard < 50) begin
            @(posedge clock);
            #1;
            guard++;
        end
        check_eq("drain_empty", exp_q.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
